// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between video_timing_gen and the downstream pattern stages.
// frame_start is only present when VTG_FRAME_START_EN is defined.
interface video_timing_gen_if;
  logic        en;
  logic [15:0] hactive;
  logic [15:0] vactive;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] x;
  logic [11:0] y;
`ifdef VTG_FRAME_START_EN
  logic        frame_start;
`endif

  modport master (
    input  en,
    output hactive, vactive, hs, vs, de, x, y
`ifdef VTG_FRAME_START_EN
    , output frame_start
`endif
  );

  modport slave (
    output en,
    input  hactive, vactive, hs, vs, de, x, y
`ifdef VTG_FRAME_START_EN
    , input frame_start
`endif
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters plus registered hs/vs/de/x/y decode (1-clock latency).
// Optional one-clock frame_start pulse when VTG_FRAME_START_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  video_timing_gen_if.master vtg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit thresholds so a window ending exactly at 4096 still compares correctly.
  localparam logic [12:0] H_LAST     = 13'(H_TOTAL - 1);
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_LAST     = 13'(V_TOTAL - 1);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [11:0] h_cnt_reg, h_cnt_next;
  logic [11:0] v_cnt_reg, v_cnt_next;
  logic        hs_reg, hs_next;
  logic        vs_reg, vs_next;
  logic        de_reg, de_next;
  logic [11:0] x_reg, x_next;
  logic [11:0] y_reg, y_next;

  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic        h_at_end;
  logic        v_at_end;

  assign h_ext    = {1'b0, h_cnt_reg};
  assign v_ext    = {1'b0, v_cnt_reg};
  assign h_at_end = (h_ext == H_LAST);
  assign v_at_end = (v_ext == V_LAST);

  // Counter advance; en low parks both counters at the frame origin.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (!vtg.en) begin
      h_cnt_next = '0;
      v_cnt_next = '0;
    end else if (h_at_end) begin
      h_cnt_next = '0;
      v_cnt_next = v_at_end ? 12'd0 : v_cnt_reg + 12'd1;
    end else begin
      h_cnt_next = h_cnt_reg + 12'd1;
    end
  end

  // Decode of the current counters; registered below. Gated by en so outputs idle one clock after en drops.
  always_comb begin
    de_next = vtg.en && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    hs_next = (vtg.en && (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? HS_ON : ~HS_ON;
    vs_next = (vtg.en && (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? VS_ON : ~VS_ON;
    x_next  = de_next ? h_cnt_reg : 12'd0;
    y_next  = de_next ? v_cnt_reg : 12'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      hs_reg    <= ~HS_ON;
      vs_reg    <= ~VS_ON;
      de_reg    <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
      hs_reg    <= hs_next;
      vs_reg    <= vs_next;
      de_reg    <= de_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  assign vtg.hactive = 16'(H_ACTIVE);
  assign vtg.vactive = 16'(V_ACTIVE);
  assign vtg.hs      = hs_reg;
  assign vtg.vs      = vs_reg;
  assign vtg.de      = de_reg;
  assign vtg.x       = x_reg;
  assign vtg.y       = y_reg;

`ifdef VTG_FRAME_START_EN
  logic frame_start_reg, frame_start_next;

  // Lines up with the output cycle carrying de=1, x=0, y=0.
  assign frame_start_next = vtg.en && (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_start_next;
    end
  end

  assign vtg.frame_start = frame_start_reg;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator; sits directly upstream of the mv_pattern* test-pattern stages.
- Produces timing_hs/vs/de plus pixel coordinates x/y and the hactive/vactive constants those stages consume.
- Runs on the pixel clock and drives one frame of H_TOTAL x V_TOTAL pixel clocks.
- Scan order per line and per frame: active, front porch, sync, back porch.

Parameters:
- H_ACTIVE, 1920: active pixels per line.
- H_FP, 88: horizontal front porch, in clocks.
- H_SYNC, 44: horizontal sync width, in clocks.
- H_BP, 148: horizontal back porch, in clocks.
- V_ACTIVE, 1080: active lines per frame.
- V_FP, 4: vertical front porch, in lines.
- V_SYNC, 5: vertical sync width, in lines.
- V_BP, 36: vertical back porch, in lines.
- HS_POL, 1: hs level during sync (1 = active-high).
- VS_POL, 1: vs level during sync (1 = active-high).

Ports:
- clk  input  1  pixel clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low holds the generator idle at frame origin.
- hactive  output  16  constant H_ACTIVE.
- vactive  output  16  constant V_ACTIVE.
- hs  output  1  horizontal sync.
- vs  output  1  vertical sync.
- de  output  1  data enable; high for active pixels only.
- x  output  12  active pixel column; 0 outside active region.
- y  output  12  active line; 0 outside active region.
- frame_start  output  1  present only with VTG_FRAME_START_EN.

Behaviour:
- Derived widths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal counters: h_cnt (0..H_TOTAL-1), v_cnt (0..V_TOTAL-1), each 12 bits.
- Counter advance: h_cnt increments every clock while en=1 and wraps to 0 after H_TOTAL-1.
- v_cnt increments when h_cnt==H_TOTAL-1 and wraps to 0 after V_TOTAL-1.
- Reset (rst_n low, async): h_cnt=v_cnt=0; hs=!HS_POL, vs=!VS_POL; de=0, x=0, y=0; frame_start=0. hactive/vactive are constant and unaffected by reset.
- Output decode, all registered; outputs at cycle n+1 reflect counters at cycle n (1-cycle latency):
  - de = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - vs = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else !VS_POL. vs toggles only on cycles following h_cnt==0 (whole-line granularity).
  - x = h_cnt[11:0] and y = v_cnt[11:0] when the de condition is true; x=y=0 otherwise.
- en low:
  - Counters cleared to 0 synchronously.
  - On the next clock, outputs go idle: de=0, x=y=0, hs/vs inactive.
  - en rising starts a fresh frame: the first cycle with en=1 has counter (0,0), so de=1 with x=0, y=0 one clock later.
- en dropped mid-frame: abort immediately, no completion of the line or frame. Re-enable always restarts at (0,0).
- Reset mid-frame: identical to power-up; counting resumes from (0,0) after rst_n release, provided en=1.
- Width rule: H_TOTAL and V_TOTAL must each be <= 4096 (12-bit). Comparisons are unsigned.

Optional Feature:
- Macro: VTG_FRAME_START_EN.
- Defined: the frame_start port exists.
  - One-clock pulse, registered, aligned with the output cycle carrying x=0, y=0, de=1.
  - Fires once per frame, including the first frame after en rises or after reset.
- Undefined: the frame_start port and its register are absent; all other behaviour is identical.

Test Plan:
- Small timing used throughout: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), frame of 128 clocks.
- Reset then en=1: first de=1 one clock after the first enabled edge, with x=0, y=0. Line 0 shows de high for 8 clocks with x stepping 0..7. de low for 8 clocks, during which hs=1 on clocks 10..12 of the line.
- Full frame:
  - de high on lines 0..3 only.
  - vs=1 for exactly 32 clocks, covering lines 5..6.
  - Pattern repeats every 128 clocks.
  - x never exceeds 7; y never exceeds 3.
- HS_POL=0, VS_POL=0: hs/vs idle high and pulse low over the same windows; reset value is hs=vs=1.
- en dropped at line 2, x=5: one clock later de=0, x=y=0. Re-enable: next frame starts at x=0, y=0 with no partial line.
- rst_n asserted mid-frame asynchronously (between clock edges): outputs idle immediately. After release, timing is identical to power-up.
- VTG_FRAME_START_EN defined: frame_start pulses once every 128 clocks, coincident with de=1, x=0, y=0. No pulse while en=0.
